alu_op_driver: RTL and testbench
================================

ALU_OP_DRIVER -- requirements
Module: alu_op_driver

Interface
REQ-001 The module SHALL have parameters, one per line: name, default, meaning.
- WIDTH, 16, operand/result width
- SETTLE, 1, cycles alu_a/alu_b are held stable before alu_y is sampled (1..15)
- DEPTH, 2, result buffer entries (power of two)

REQ-002 The module SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- req_valid, in, 1, operand pair offered
- req_ready, out, 1, driver accepts pair
- req_a, in, WIDTH, operand A
- req_b, in, WIDTH, operand B
- alu_a, out, WIDTH, operand A to combinational bitwise unit
- alu_b, out, WIDTH, operand B to combinational bitwise unit
- alu_y, in, WIDTH, combinational result returned by unit
- rsp_valid, out, 1, result available
- rsp_ready, in, 1, consumer takes result
- rsp_data, out, WIDTH, result at buffer head
- op_count, out, 8, completed-operation counter

REQ-003 The design SHALL use one clock; reset SHALL be asynchronous and active-low (clk, rst_n).

Function
REQ-004 The FSM SHALL have states IDLE, DRIVE, CAPTURE.
REQ-005 In IDLE, req_ready SHALL be 1 iff the result buffer has at least one free entry, counting any entry reserved by an operation in flight.
REQ-006 On req_valid && req_ready in IDLE, the driver SHALL register req_a/req_b onto alu_a/alu_b, load the settle counter with SETTLE, and go to DRIVE.
REQ-007 In DRIVE, alu_a/alu_b SHALL stay constant; the counter SHALL decrement each cycle, and at 0 the FSM SHALL go to CAPTURE.
REQ-008 In CAPTURE, alu_y SHALL be written into the buffer, op_count SHALL increment (modulo 256, 255 wraps to 0), and the FSM SHALL return to IDLE.
REQ-009 req_ready SHALL be 0 in DRIVE and CAPTURE (one operation in flight maximum).
REQ-010 Latency from request accept to rsp_valid SHALL be SETTLE+2 cycles when the buffer is empty.
REQ-011 rsp_valid SHALL be 1 iff the buffer is non-empty; rsp_data SHALL show the oldest entry; rsp_valid && rsp_ready SHALL pop one entry.
REQ-012 rsp_valid/rsp_data SHALL remain stable while rsp_valid && !rsp_ready.
REQ-013 A simultaneous CAPTURE write and consumer pop SHALL leave occupancy unchanged, with order preserved (FIFO).
REQ-014 With DEPTH entries full, no new request SHALL be accepted until a pop occurs; a pop and an accept in the same cycle SHALL both take effect.
REQ-015 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-016 alu_a/alu_b SHALL hold their last driven values in IDLE.

Reset
REQ-017 Asserting rst_n low SHALL immediately force the FSM to IDLE, clear alu_a/alu_b to 0, clear op_count to 0, empty the buffer (rsp_valid=0, rsp_data=0), and set req_ready=1 after the first clock following deassertion.
REQ-018 Reset mid-operation SHALL discard the in-flight operation with no result produced and no op_count increment.

Structure
REQ-019 Package alu_pkg SHALL hold WIDTH default (16), the FSM state typedef (IDLE/DRIVE/CAPTURE), and the op_count width constant (8).
REQ-020 The result buffer SHALL be a sub-module alu_rsp_fifo (WIDTH, DEPTH parameters, push/pop/full/empty); the FSM and counters SHALL stay in alu_op_driver.

Verification
REQ-021 The bench SHALL bind alu_y = alu_a | alu_b and cover the following scenarios:
- Single op: a=16'h5555, b=16'hAAAA, SETTLE=1 -> rsp_data=16'hFFFF, rsp_valid exactly 3 cycles after accept, op_count=1.
- Backpressure: rsp_ready=0 and three requests (0000/0000, FFFF/AAAA, 00F0/0F00) -> two accepted, third stalled (req_ready=0); releasing rsp_ready -> results 0000, FFFF, 0FF0 in order.
- Simultaneous push/pop, DEPTH=2, buffer holding 1 entry -> occupancy stays 1, order intact.
- Reset in DRIVE: assert rst_n low during DRIVE -> rsp_valid=0, op_count=0, alu_a=alu_b=0 immediately; no result appears later.
- Counter wrap: 256 ops with rsp_ready=1 -> op_count returns to 0.
- SETTLE=3: alu_a/alu_b stable for 3 DRIVE cycles, latency 5 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and FSM state type for the ALU operand driver.
package alu_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned OPCNT_W   = 8;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Result FIFO with a registered head: head_valid/head_data come straight from flops.
module alu_rsp_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr, rd_ptr, wr_next, rd_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head_next;
    logic             do_push, do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A push into the slot that becomes the head must bypass the memory.
    always_comb begin
        do_push   = push && !full;
        do_pop    = pop && !empty;
        wr_next   = wr_ptr + PW'(do_push);
        rd_next   = rd_ptr + PW'(do_pop);
        head_next = mem[rd_next[AW-1:0]];
        if (do_push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
            head_next = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
            end
            wr_ptr     <= wr_next;
            rd_ptr     <= rd_next;
            head_valid <= (wr_next != rd_next);
            head_data  <= head_next;
        end
    end

endmodule

// File: rtl/alu_op_driver.sv
// Drives operand pairs into a combinational bitwise unit, waits SETTLE cycles,
// and captures the result into a small response FIFO.
module alu_op_driver #(
    parameter int unsigned WIDTH  = alu_pkg::WIDTH_DEF,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [WIDTH-1:0]            req_a,
    input  logic [WIDTH-1:0]            req_b,
    output logic [WIDTH-1:0]            alu_a,
    output logic [WIDTH-1:0]            alu_b,
    input  logic [WIDTH-1:0]            alu_y,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [WIDTH-1:0]            rsp_data,
    output logic [alu_pkg::OPCNT_W-1:0] op_count
);

    import alu_pkg::*;

    localparam int unsigned FW = $clog2(DEPTH) + 1;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     alu_a_d, alu_b_d;
    logic [OPCNT_W-1:0]   op_count_d;
    logic                 req_ready_d;
    logic                 push, pop;
    logic                 fifo_full, fifo_empty;
    logic [FW-1:0]        fill, fill_next;

    assign pop = rsp_ready && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            op_count  <= '0;
            req_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            op_count  <= op_count_d;
            req_ready <= req_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a;
        alu_b_d    = alu_b;
        op_count_d = op_count;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    alu_a_d = req_a;
                    alu_b_d = req_b;
                    cnt_d   = CNT_W'(SETTLE);
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                push       = !fifo_full;
                op_count_d = op_count + OPCNT_W'(1);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Ready only when idle next cycle with a free slot left after this cycle's push/pop.
        fill_next   = fill + FW'(push) - FW'(pop);
        req_ready_d = (state_d == IDLE) && (fill_next < FW'(DEPTH));
    end

    alu_rsp_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .din        (alu_y),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fill),
        .head_valid (rsp_valid),
        .head_data  (rsp_data)
    );

endmodule

// File: tb/tb_alu_op_driver.sv
// Self-checking bench for alu_op_driver: directed scenarios plus randomized traffic
// against a queue-based reference of expected results.
module tb_alu_op_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1_n, rst3_n;
    logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1;
    logic [15:0] req_a1, req_b1, alu_a1, alu_b1, alu_y1, rsp_data1;
    logic [7:0]  op_count1;
    logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3;
    logic [15:0] req_a3, req_b3, alu_a3, alu_b3, alu_y3, rsp_data3;
    logic [7:0]  op_count3;

    assign alu_y1 = alu_a1 | alu_b1;
    assign alu_y3 = alu_a3 | alu_b3;

    alu_op_driver #(.WIDTH(16), .SETTLE(1), .DEPTH(2)) dut1 (
        .clk(clk), .rst_n(rst1_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_a(req_a1), .req_b(req_b1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_y(alu_y1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .op_count(op_count1)
    );

    alu_op_driver #(.WIDTH(16), .SETTLE(3), .DEPTH(2)) dut3 (
        .clk(clk), .rst_n(rst3_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_y(alu_y3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .op_count(op_count3)
    );

    int          checks = 0;
    int          failures = 0;
    logic [15:0] q1[$];
    bit          acc1, hold1;
    logic [15:0] held1;
    int          exp_cnt1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Score the handshakes the next rising edge will see, then advance to the next falling edge.
    task automatic cyc1();
        if (hold1) begin
            chk("hold_valid", 32'(rsp_valid1), 1);
            chk("hold_data", 32'(rsp_data1), 32'(held1));
        end
        hold1 = rsp_valid1 && !rsp_ready1;
        held1 = rsp_data1;
        if (rsp_valid1 && rsp_ready1) begin
            if (q1.size() == 0) chk("unexpected_rsp", 32'(rsp_valid1), 0);
            else                chk("rsp_data", 32'(rsp_data1), 32'(q1.pop_front()));
        end
        acc1 = req_valid1 && req_ready1;
        if (acc1) begin
            q1.push_back(req_a1 | req_b1);
            exp_cnt1++;
        end
        @(negedge clk);
    endtask

    task automatic send1(input logic [15:0] a, input logic [15:0] b, input int budget, output bit ok);
        int n = 0;
        req_valid1 = 1'b1;
        req_a1     = a;
        req_b1     = b;
        do begin
            cyc1();
            n++;
        end while (!acc1 && n < budget);
        ok = acc1;
    endtask

    task automatic wait_rsp1(output int lat);
        lat = 1;
        while (!rsp_valid1 && lat < 40) begin
            cyc1();
            lat++;
        end
    endtask

    task automatic drain1();
        int n = 0;
        rsp_ready1 = 1'b1;
        while ((q1.size() != 0 || rsp_valid1) && n < 200) begin
            cyc1();
            n++;
        end
        chk("drain_outstanding", 32'(q1.size()), 0);
        chk("drain_rsp_valid", 32'(rsp_valid1), 0);
        rsp_ready1 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int lat;
        int n;
        int n_ok;

        rst1_n = 1'b0; rst3_n = 1'b0;
        req_valid1 = 1'b0; req_a1 = '0; req_b1 = '0; rsp_ready1 = 1'b0;
        req_valid3 = 1'b0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b0;
        acc1 = 1'b0; hold1 = 1'b0; held1 = '0; exp_cnt1 = 0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_req_ready", 32'(req_ready1), 0);
        chk("rst_rsp_valid", 32'(rsp_valid1), 0);
        chk("rst_rsp_data", 32'(rsp_data1), 0);
        chk("rst_op_count", 32'(op_count1), 0);
        chk("rst_alu_a", 32'(alu_a1), 0);
        chk("rst_alu_b", 32'(alu_b1), 0);
        rst1_n = 1'b1; rst3_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready1", 32'(req_ready1), 1);
        chk("post_rst_ready3", 32'(req_ready3), 1);

        // Single op, SETTLE=1
        chk("single_ready", 32'(req_ready1), 1);
        send1(16'h5555, 16'hAAAA, 1, ok);
        req_valid1 = 1'b0;
        chk("single_accept", 32'(ok), 1);
        chk("drive_alu_a", 32'(alu_a1), 32'h5555);
        chk("drive_alu_b", 32'(alu_b1), 32'hAAAA);
        chk("drive_req_ready", 32'(req_ready1), 0);
        wait_rsp1(lat);
        chk("single_latency", 32'(lat), 3);
        chk("single_data", 32'(rsp_data1), 32'hFFFF);
        chk("single_op_count", 32'(op_count1), 1);
        drain1();
        chk("idle_hold_a", 32'(alu_a1), 32'h5555);
        chk("idle_hold_b", 32'(alu_b1), 32'hAAAA);

        // Backpressure: two fit, third stalls until a pop
        send1(16'h0000, 16'h0000, 20, ok);
        chk("bp_acc0", 32'(ok), 1);
        send1(16'hFFFF, 16'hAAAA, 20, ok);
        chk("bp_acc1", 32'(ok), 1);
        send1(16'h00F0, 16'h0F00, 12, ok);
        chk("bp_stall", 32'(ok), 0);
        chk("bp_req_ready", 32'(req_ready1), 0);
        chk("bp_valid", 32'(rsp_valid1), 1);
        chk("bp_head", 32'(rsp_data1), 32'h0000);
        rsp_ready1 = 1'b1;
        n = 0;
        do begin
            cyc1();
            n++;
        end while (!acc1 && n < 20);
        chk("bp_third_accept", 32'(acc1), 1);
        req_valid1 = 1'b0;
        drain1();

        // Simultaneous push and pop with one entry buffered
        send1(16'h1234, 16'h0001, 20, ok);
        req_valid1 = 1'b0;
        wait_rsp1(lat);
        chk("pp_first_valid", 32'(rsp_valid1), 1);
        send1(16'h0A0A, 16'h5050, 20, ok);
        req_valid1 = 1'b0;
        chk("pp_second_accept", 32'(ok), 1);
        cyc1();
        rsp_ready1 = 1'b1;
        cyc1();
        rsp_ready1 = 1'b0;
        chk("pp_valid", 32'(rsp_valid1), 1);
        chk("pp_order", 32'(rsp_data1), 32'h5A5A);
        chk("pp_req_ready", 32'(req_ready1), 1);
        rsp_ready1 = 1'b1;
        cyc1();
        rsp_ready1 = 1'b0;
        chk("pp_single_entry", 32'(rsp_valid1), 0);

        // Reset while in DRIVE with a buffered result
        send1(16'h00FF, 16'h0000, 20, ok);
        req_valid1 = 1'b0;
        wait_rsp1(lat);
        send1(16'h1111, 16'h2222, 20, ok);
        req_valid1 = 1'b0;
        hold1 = 1'b0;
        rst1_n = 1'b0;
        #1;
        chk("rst_drive_rsp_valid", 32'(rsp_valid1), 0);
        chk("rst_drive_rsp_data", 32'(rsp_data1), 0);
        chk("rst_drive_op_count", 32'(op_count1), 0);
        chk("rst_drive_alu_a", 32'(alu_a1), 0);
        chk("rst_drive_alu_b", 32'(alu_b1), 0);
        q1.delete();
        exp_cnt1 = 0;
        repeat (2) @(negedge clk);
        rst1_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_no_result", 32'(rsp_valid1), 0);
        chk("rst_no_count", 32'(op_count1), 0);

        // Counter wrap with random operands, consumer always ready
        rsp_ready1 = 1'b1;
        n_ok = 0;
        for (int i = 0; i < 255; i++) begin
            send1(16'($urandom), 16'($urandom), 20, ok);
            if (ok) n_ok++;
        end
        req_valid1 = 1'b0;
        drain1();
        chk("wrap_255", 32'(op_count1), 32'd255);
        rsp_ready1 = 1'b1;
        send1(16'($urandom), 16'($urandom), 20, ok);
        if (ok) n_ok++;
        req_valid1 = 1'b0;
        drain1();
        chk("wrap_accepts", 32'(n_ok), 256);
        chk("wrap_zero", 32'(op_count1), 0);

        // Random traffic with random backpressure
        acc1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rsp_ready1 = 1'($urandom_range(0, 1));
            if (acc1 || !req_valid1) begin
                req_valid1 = 1'($urandom_range(0, 1));
                req_a1     = 16'($urandom);
                req_b1     = 16'($urandom);
            end
            cyc1();
        end
        req_valid1 = 1'b0;
        drain1();
        chk("rand_op_count", 32'(op_count1), 32'(exp_cnt1 % 256));

        // SETTLE=3: operands stable three DRIVE cycles, latency five
        chk("s3_ready", 32'(req_ready3), 1);
        req_valid3 = 1'b1;
        req_a3     = 16'h1234;
        req_b3     = 16'h00FF;
        @(negedge clk);
        req_valid3 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk("s3_alu_a", 32'(alu_a3), 32'h1234);
            chk("s3_alu_b", 32'(alu_b3), 32'h00FF);
            chk("s3_early", 32'(rsp_valid3), 0);
            @(negedge clk);
        end
        lat = 4;
        while (!rsp_valid3 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("s3_latency", 32'(lat), 5);
        chk("s3_data", 32'(rsp_data3), 32'h12FF);
        chk("s3_op_count", 32'(op_count3), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
